// File: rtl/core_pkg.sv
// Shared core definitions: funct3 size/sign codes, result-source encoding
// and the memory-access FSM state type.
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mau_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: store steering and byte enables, load lane
// extraction with sign/zero extension, and misalignment detection.
module lsu_lane_align
    import core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  i_store,
    input  logic [2:0]            i_funct3,
    input  logic [1:0]            i_off,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [BE_WIDTH-1:0]   o_be,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [DATA_WIDTH-1:0] o_load,
    output logic                  o_misaligned
);

    logic [DATA_WIDTH-1:0] w_shifted;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;

    assign w_shifted = i_rdata >> {i_off, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = w_shifted[15:0];

    // Size decode; any funct3 not naming a byte or half is a word access
    always_comb begin
        o_be         = '1;
        o_wdata      = '0;
        o_load       = i_rdata;
        o_misaligned = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                if (i_store) begin
                    o_be    = BE_WIDTH'(4'b0001 << i_off);
                    o_wdata = {(DATA_WIDTH/8){i_wdata[7:0]}};
                end
                o_load = (i_funct3 == F3_B) ? {{(DATA_WIDTH-8){w_byte[7]}}, w_byte}
                                            : {{(DATA_WIDTH-8){1'b0}}, w_byte};
            end
            F3_H, F3_HU: begin
                o_misaligned = i_off[0];
                if (i_store) begin
                    o_be    = BE_WIDTH'(4'b0011 << i_off);
                    o_wdata = {(DATA_WIDTH/16){i_wdata[15:0]}};
                end
                o_load = (i_funct3 == F3_H) ? {{(DATA_WIDTH-16){w_half[15]}}, w_half}
                                            : {{(DATA_WIDTH-16){1'b0}}, w_half};
            end
            default: begin
                o_misaligned = (i_off != 2'b00);
                if (i_store) begin
                    o_wdata = i_wdata;
                end
            end
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// M-stage memory access unit: issues one data-memory request per load/store,
// stalls the pipeline until the handshake completes, then presents the result.
module memory_access_unit
    import core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ValidM,
    input  logic                  MemWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic [2:0]            AddressingControlM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [BE_WIDTH-1:0]   mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  MisalignedM
);

    mau_state_t            r_state;
    mau_state_t            w_next;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_flush;

    logic                  w_access;
    logic                  w_is_load;
    logic                  w_capture;
    logic                  w_req;
    logic                  w_stall;
    logic                  w_misal;
    logic [DATA_WIDTH-1:0] w_rd;
    logic [BE_WIDTH-1:0]   w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_load;
    logic                  w_misaligned;

    assign w_access  = ValidM & (MemWriteM | (ResultSrcM == RESULT_SRC_MEM));
    assign w_is_load = w_access & ~MemWriteM;

    lsu_lane_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .BE_WIDTH   (BE_WIDTH)
    ) u_lane (
        .i_store      (MemWriteM),
        .i_funct3     (AddressingControlM),
        .i_off        (ALUResultM[1:0]),
        .i_wdata      (WriteDataM),
        .i_rdata      (r_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load       (w_load),
        .o_misaligned (w_misaligned)
    );

    // State, captured read word, and flush-during-wait marker
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rdata <= '0;
            r_flush <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_rdata <= mem_rdata;
            end
            if (r_state == IDLE) begin
                r_flush <= 1'b0;
            end else if ((r_state == BUSY) && !ValidM) begin
                r_flush <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_req     = 1'b0;
        w_stall   = 1'b0;
        w_misal   = 1'b0;
        w_rd      = '0;
        case (r_state)
            IDLE: begin
                if (w_access && w_misaligned) begin
                    w_misal = 1'b1;
                end else if (w_access) begin
                    w_req   = 1'b1;
                    w_stall = 1'b1;
                    if (mem_ready) begin
                        w_capture = 1'b1;
                        w_next    = DONE;
                    end else begin
                        w_next = BUSY;
                    end
                end
            end
            // A flushed request still finishes its handshake here
            BUSY: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (mem_ready) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
                if (w_is_load && !r_flush) begin
                    w_rd = w_load;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign mem_req     = w_req & ~rst;
    assign StallM      = w_stall & ~rst;
    assign MisalignedM = w_misal & ~rst;
    assign ReadDataM   = rst ? '0 : w_rd;
    assign mem_we      = mem_req & MemWriteM;
    assign mem_be      = mem_req ? w_be : '0;
    assign mem_wdata   = mem_req ? w_wdata : '0;
    assign mem_addr    = mem_req ? {ALUResultM[DATA_WIDTH-1:2], 2'b00} : '0;

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Memory (M) stage of the pipelined core. Sits directly downstream of the EX/MEM register.
- Consumes that register's outputs (ALUResultM, WriteDataM, MemWriteM, ResultSrcM, AddressingControlM) and performs byte/half/word loads and stores against a variable-latency data-memory port.
- Stalls the pipeline until each access completes.
- Delivers the sign- or zero-extended load result to the MEM/WB register.

Parameters:
- DATA_WIDTH, 32, data and address width; only 32 is supported.
- BE_WIDTH, 4, byte enables; always DATA_WIDTH/8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ValidM  in  1  the M-stage slot holds a real instruction.
- MemWriteM  in  1  store.
- ResultSrcM  in  2  2'b01 means load.
- AddressingControlM  in  3  funct3 size/sign code.
- ALUResultM  in  DATA_WIDTH  byte address.
- WriteDataM  in  DATA_WIDTH  store data (rs2).
- mem_req  out  1  request to data memory.
- mem_we  out  1  write enable.
- mem_addr  out  DATA_WIDTH  word-aligned address, {ALUResultM[31:2],2'b00}.
- mem_be  out  BE_WIDTH  byte enables.
- mem_wdata  out  DATA_WIDTH  lane-steered store data.
- mem_ready  in  1  memory accepted or returned data this cycle.
- mem_rdata  in  DATA_WIDTH  read word, valid when mem_ready.
- ReadDataM  out  DATA_WIDTH  extended load result.
- StallM  out  1  freeze IF/ID/EX/MEM registers.
- MisalignedM  out  1  access aborted due to misalignment.

Behaviour:
- Definitions:
  - access = ValidM & (MemWriteM | ResultSrcM==2'b01).
  - If both are set, the access is a store (store priority).
  - off = ALUResultM[1:0].
- Misalignment:
  - Halfword (funct3 x01) with off[0]=1, or word (x10) with off!=0.
  - Response: MisalignedM=1 combinationally; no mem_req; StallM=0; ReadDataM=0.
  - Unused funct3 codes (011, 110, 111) are word accesses.
- FSM states IDLE, BUSY, DONE; reset leaves the FSM in IDLE.
- IDLE:
  - Aligned access: mem_req=1 and StallM=1.
  - If mem_ready in the same cycle: capture mem_rdata into rdata_q and go to DONE; otherwise go to BUSY.
  - No access: stay in IDLE, all outputs 0.
- BUSY:
  - mem_req=1 and StallM=1; request fields held stable (inputs are frozen by the stall).
  - On mem_ready: capture rdata_q and go to DONE.
  - No timeout.
- DONE:
  - mem_req=0 and StallM=0.
  - Loads: ReadDataM = extend(rdata_q); stores: ReadDataM=0.
  - Pipeline advances at the end of this cycle; next state is IDLE.
- Latency: minimum 2 cycles per access (IDLE+DONE); 1 extra cycle per memory wait cycle.
- Store steering:
  - SB: be=4'b0001<<off, wdata={4{WriteDataM[7:0]}}.
  - SH: be=4'b0011<<off, wdata={2{WriteDataM[15:0]}}.
  - SW: be=4'b1111, wdata=WriteDataM.
- Loads: mem_we=0, be=4'b1111.
- Load extension:
  - Select the byte or half at lane off.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Reset values:
  - State IDLE, rdata_q=0.
  - mem_req, mem_we, mem_be, mem_wdata, ReadDataM, StallM, MisalignedM all 0.
- Reset mid-operation (BUSY or DONE): next cycle IDLE with mem_req=0; any later mem_ready for the dropped request is ignored.
- ValidM deasserted while in BUSY (flush): complete the outstanding handshake, then go to DONE with ReadDataM forced to 0. The bus protocol is never abandoned mid-request.
- mem_ready high in DONE or in IDLE without a request: ignored.

Decomposition:
- Shared package core_pkg holds:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - RESULT_SRC_MEM=2'b01.
  - The mau_state_t enum {IDLE, BUSY, DONE}.
- One combinational sub-module, lsu_lane_align: store lane steering, byte enables, load extraction/extension, misalignment detect.
- The FSM and rdata_q stay in the parent.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, mem_ready=1 immediately -> mem_req=1, be=1111, addr=0x100 for 1 cycle; StallM 1 then 0; 2 cycles total.
- LB addr 0x203, mem_rdata=0x80112233, 3 wait cycles -> StallM high 4 cycles; DONE ReadDataM=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH addr 0x42, data 0x0000ABCD -> be=1100, wdata=0xABCDABCD. LH addr 0x41 -> MisalignedM=1, mem_req=0, StallM=0.
- LHU addr 0x12, rdata=0x9876_0000 -> ReadDataM=0x00009876. LH on the same data -> 0xFFFF9876.
- rst asserted in BUSY -> next cycle state IDLE, mem_req=0, StallM=0. A late mem_ready is ignored; ReadDataM=0.
- MemWriteM=1 with ResultSrcM=01 -> store performed (mem_we=1). ValidM=0 with MemWriteM=1 -> no mem_req.
